// File: rtl/cpu_ram_responder.sv
// Data-RAM port responder for the cpu: zero-wait RAM plus an 8-register I/O window
// (GPO, synchronised GPI, TX byte FIFO with status, coherent 16-bit tick counter).
module cpu_ram_responder #(
    parameter int                    g_RAM_WIDTH  = 9,
    parameter int                    g_RAM_ADDR   = 11,
    parameter logic [g_RAM_ADDR-1:0] g_IO_BASE    = 11'h7F8,
    parameter int                    g_FIFO_DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ram_en,
    input  logic                   i_ram_we,
    input  logic                   i_ram_re,
    input  logic [g_RAM_ADDR-1:0]  i_ram_addr,
    input  logic [g_RAM_WIDTH-1:0] i_ram_data,
    output logic [g_RAM_WIDTH-1:0] o_ram_data,
    input  logic [7:0]             i_gpi,
    output logic [7:0]             o_gpo,
    output logic                   o_tx_valid,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_ready
);

    localparam int PW = (g_FIFO_DEPTH > 1) ? $clog2(g_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IO_GPO     = 3'd0,
        IO_GPI     = 3'd1,
        IO_TXDATA  = 3'd2,
        IO_STATUS  = 3'd3,
        IO_TICK_LO = 3'd4,
        IO_TICK_HI = 3'd5,
        IO_RSV6    = 3'd6,
        IO_RSV7    = 3'd7
    } io_reg_e;

    // Address decode
    logic [g_RAM_ADDR-1:0] io_off;
    logic                  is_io;
    logic                  io_hit;
    io_reg_e               io_sel;
    logic                  wr_cyc;
    logic                  rd_cyc;

    assign io_off = i_ram_addr - g_IO_BASE;
    assign is_io  = (i_ram_addr >= g_IO_BASE);
    assign io_hit = is_io && (io_off[g_RAM_ADDR-1:3] == '0);
    assign io_sel = io_reg_e'(io_off[2:0]);
    assign wr_cyc = i_ram_en & i_ram_we;
    assign rd_cyc = i_ram_en & i_ram_re;

    logic ram_wr;
    logic gpo_wr;
    logic push_req;
    logic status_wr;
    logic tick_lo_rd;

    assign ram_wr     = wr_cyc & ~is_io;
    assign gpo_wr     = wr_cyc & io_hit & (io_sel == IO_GPO);
    assign push_req   = wr_cyc & io_hit & (io_sel == IO_TXDATA);
    assign status_wr  = wr_cyc & io_hit & (io_sel == IO_STATUS);
    assign tick_lo_rd = rd_cyc & io_hit & (io_sel == IO_TICK_LO);

    // Data RAM
    logic [g_RAM_WIDTH-1:0] ram [0:(1<<g_RAM_ADDR)-1];

    // NOTE: memory arrays carry no reset; only the write is blocked on the reset edge.
    always_ff @(posedge i_clk) begin
        if (ram_wr && !i_rst) begin
            ram[i_ram_addr] <= i_ram_data;
        end
    end

    // Registered state
    logic [7:0]    gpo_q;
    logic [7:0]    gpi_s1_q;
    logic [7:0]    gpi_s2_q;
    logic [15:0]   tick_q;
    logic [7:0]    snap_q;
    logic          ovf_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          tx_valid_q;
    logic [7:0]    tx_data_q;
    logic [7:0]    fifo_mem [0:g_FIFO_DEPTH-1];

    logic          full;
    logic          empty;
    logic          pop;
    logic          push_acc;
    logic          drop;
    logic [CW-1:0] count_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [7:0]    head_nxt;

    assign full     = (count_q == CW'(g_FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = tx_valid_q & i_tx_ready;
    assign push_acc = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // The head register must see the byte being pushed when it lands in the slot
    // that becomes the head this cycle (push into empty, or push+pop at count 1).
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_nxt  = count_q;
        rd_ptr_nxt = rd_ptr_q;
        head_nxt   = 8'h00;
        case ({push_acc, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
        if (pop) begin
            rd_ptr_nxt = rd_ptr_q + PW'(1);
        end
        if (count_nxt != '0) begin
            if (push_acc && (rd_ptr_nxt == wr_ptr_q)) begin
                head_nxt = i_ram_data[7:0];
            end else begin
                head_nxt = fifo_mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_acc && !i_rst) begin
            fifo_mem[wr_ptr_q] <= i_ram_data[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gpo_q      <= 8'h00;
            gpi_s1_q   <= 8'h00;
            gpi_s2_q   <= 8'h00;
            tick_q     <= 16'h0000;
            snap_q     <= 8'h00;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            gpi_s1_q <= i_gpi;
            gpi_s2_q <= gpi_s1_q;
            tick_q   <= tick_q + 16'd1;
            if (gpo_wr) begin
                gpo_q <= i_ram_data[7:0];
            end
            if (tick_lo_rd) begin
                snap_q <= tick_q[15:8];
            end
            // Setting takes priority over a same-cycle clear.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (status_wr) begin
                ovf_q <= 1'b0;
            end
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            rd_ptr_q   <= rd_ptr_nxt;
            count_q    <= count_nxt;
            tx_valid_q <= (count_nxt != '0);
            tx_data_q  <= head_nxt;
        end
    end

    // Read mux
    logic [7:0] status;
    logic [7:0] io_rdata;

    assign status = {4'(count_q), 1'b0, ovf_q, full, empty};

    always_comb begin
        io_rdata = 8'h00;
        if (io_hit) begin
            case (io_sel)
                IO_GPO:     io_rdata = gpo_q;
                IO_GPI:     io_rdata = gpi_s2_q;
                IO_STATUS:  io_rdata = status;
                IO_TICK_LO: io_rdata = tick_q[7:0];
                IO_TICK_HI: io_rdata = snap_q;
                default:    io_rdata = 8'h00;
            endcase
        end
    end

    always_comb begin
        o_ram_data = '0;
        if (i_ram_en) begin
            if (is_io) begin
                o_ram_data = g_RAM_WIDTH'(io_rdata);
            end else begin
                o_ram_data = ram[i_ram_addr];
            end
        end
    end

    assign o_gpo      = gpo_q;
    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_cpu_ram_responder.sv
// Bench for cpu_ram_responder: queue/array reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_cpu_ram_responder;

    localparam int          W  = 9;
    localparam int          A  = 11;
    localparam int          D  = 8;
    localparam logic [10:0] IO = 11'h7F8;

    logic         i_clk;
    logic         i_rst;
    logic         i_ram_en;
    logic         i_ram_we;
    logic         i_ram_re;
    logic [A-1:0] i_ram_addr;
    logic [W-1:0] i_ram_data;
    logic [W-1:0] o_ram_data;
    logic [7:0]   i_gpi;
    logic [7:0]   o_gpo;
    logic         o_tx_valid;
    logic [7:0]   o_tx_data;
    logic         i_tx_ready;

    cpu_ram_responder #(
        .g_RAM_WIDTH (W),
        .g_RAM_ADDR  (A),
        .g_IO_BASE   (IO),
        .g_FIFO_DEPTH(D)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ram_en  (i_ram_en),
        .i_ram_we  (i_ram_we),
        .i_ram_re  (i_ram_re),
        .i_ram_addr(i_ram_addr),
        .i_ram_data(i_ram_data),
        .o_ram_data(o_ram_data),
        .i_gpi     (i_gpi),
        .o_gpo     (o_gpo),
        .o_tx_valid(o_tx_valid),
        .o_tx_data (o_tx_data),
        .i_tx_ready(i_tx_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state after the most recent edge
    logic [7:0]  gpo_m;
    logic [7:0]  gpi1_m;
    logic [7:0]  gpi2_m;
    logic [7:0]  snap_m;
    logic        ovf_m;
    logic [15:0] tick_m;
    logic [7:0]  q_m[$];
    logic [8:0]  ram_m[int];

    always @(posedge i_clk) begin
        if (i_rst) begin
            gpo_m  = 8'h00;
            gpi1_m = 8'h00;
            gpi2_m = 8'h00;
            snap_m = 8'h00;
            ovf_m  = 1'b0;
            tick_m = 16'h0000;
            q_m.delete();
        end else begin
            bit wr;
            wr = i_ram_en && i_ram_we;
            if (q_m.size() != 0 && i_tx_ready) void'(q_m.pop_front());
            if (wr && i_ram_addr == IO + 11'd3) ovf_m = 1'b0;
            if (wr && i_ram_addr == IO + 11'd2) begin
                if (q_m.size() < D) q_m.push_back(i_ram_data[7:0]);
                else ovf_m = 1'b1;
            end
            if (wr && i_ram_addr < IO) ram_m[int'(i_ram_addr)] = i_ram_data;
            if (wr && i_ram_addr == IO) gpo_m = i_ram_data[7:0];
            if (i_ram_en && i_ram_re && i_ram_addr == IO + 11'd4) snap_m = tick_m[15:8];
            tick_m = tick_m + 16'd1;
            gpi2_m = gpi1_m;
            gpi1_m = i_gpi;
        end
    end

    function automatic logic [8:0] exp_rd();
        logic [7:0] st;
        int n;
        n  = q_m.size();
        st = {4'(n), 1'b0, ovf_m, (n == D), (n == 0)};
        if (!i_ram_en) return 9'h000;
        if (i_ram_addr < IO) return ram_m[int'(i_ram_addr)];
        case (i_ram_addr - IO)
            11'd0:   return {1'b0, gpo_m};
            11'd1:   return {1'b0, gpi2_m};
            11'd3:   return {1'b0, st};
            11'd4:   return {1'b0, tick_m[7:0]};
            11'd5:   return {1'b0, snap_m};
            default: return 9'h000;
        endcase
    endfunction

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("tx_valid", o_tx_valid, q_m.size() != 0);
            check("tx_data", o_tx_data, (q_m.size() != 0) ? q_m[0] : 8'h00);
            check("gpo", o_gpo, gpo_m);
            if (!i_ram_en || i_ram_addr >= IO || ram_m.exists(int'(i_ram_addr)))
                check("rd_data", o_ram_data, exp_rd());
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_ram_en   = 1'b0;
        i_ram_we   = 1'b0;
        i_ram_re   = 1'b0;
        i_ram_addr = '0;
        i_ram_data = '0;
    endtask

    task automatic drive_wr(input logic [A-1:0] addr, input logic [W-1:0] data);
        i_ram_en   = 1'b1;
        i_ram_we   = 1'b1;
        i_ram_re   = 1'b0;
        i_ram_addr = addr;
        i_ram_data = data;
    endtask

    task automatic wr(input logic [A-1:0] addr, input logic [W-1:0] data);
        drive_wr(addr, data);
        step();
        idle();
    endtask

    // Leaves the read driven; the caller decides when to release it.
    task automatic rd_check(input string name, input logic [A-1:0] addr, input logic [W-1:0] exp);
        i_ram_en   = 1'b1;
        i_ram_we   = 1'b0;
        i_ram_re   = 1'b1;
        i_ram_addr = addr;
        #1;
        check(name, o_ram_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        i_rst      = 1'b1;
        i_gpi      = 8'h00;
        i_tx_ready = 1'b0;
        idle();
        step();
        chk_en = 1'b1;
        step();
        step();
        check("rst_gpo", o_gpo, 8'h00);
        check("rst_valid", o_tx_valid, 1'b0);
        check("rst_txdata", o_tx_data, 8'h00);
        i_rst = 1'b0;
        rd_check("rst_status", IO + 11'd3, 9'h001);
        idle();

        // RAM write then zero-wait read; disabled port reads zero
        wr(11'h123, 9'h1A5);
        rd_check("ram_rd", 11'h123, 9'h1A5);
        i_ram_en = 1'b0;
        #1;
        check("en0_zero", o_ram_data, 9'h000);
        idle();

        // GPO: bit 8 dropped
        wr(IO, 9'h1C3);
        check("gpo_out", o_gpo, 8'hC3);
        rd_check("gpo_rd", IO, 9'h0C3);
        idle();
        wr(IO + 11'd1, 9'h0FF);
        rd_check("gpi_wr_ignored", IO + 11'd1, 9'h000);

        // GPI two-flop latency
        i_gpi = 8'h5A;
        rd_check("gpi_edge0", IO + 11'd1, 9'h000);
        step();
        check("gpi_edge1", o_ram_data, 9'h000);
        step();
        check("gpi_edge2", o_ram_data, 9'h05A);
        idle();

        // Fill past full with sink stalled
        i_tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            drive_wr(IO + 11'd2, 9'(i));
            step();
        end
        idle();
        rd_check("status_full_ovf", IO + 11'd3, 9'h086);
        check("head_first", o_tx_data, 8'h01);
        idle();
        i_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", o_tx_data, 8'(i));
            step();
        end
        check("drained", o_tx_valid, 1'b0);
        rd_check("status_ovf_sticky", IO + 11'd3, 9'h005);
        wr(IO + 11'd3, 9'h000);
        rd_check("status_cleared", IO + 11'd3, 9'h001);
        idle();

        // Full FIFO: push with same-cycle pop is accepted
        i_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_wr(IO + 11'd2, 9'(8'h10 + i));
            step();
        end
        idle();
        rd_check("status_full", IO + 11'd3, 9'h082);
        i_tx_ready = 1'b1;
        drive_wr(IO + 11'd2, 9'h0EE);
        step();
        i_tx_ready = 1'b0;
        idle();
        rd_check("status_full_pop", IO + 11'd3, 9'h082);
        check("head_after_pop", o_tx_data, 8'h11);
        idle();
        i_tx_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("last_ee", o_tx_data, 8'hEE);
        step();
        check("empty_again", o_tx_valid, 1'b0);

        // Push into empty, then push+pop at count 1 keeps order
        drive_wr(IO + 11'd2, 9'h033);
        step();
        check("push_empty", o_tx_data, 8'h33);
        drive_wr(IO + 11'd2, 9'h044);
        step();
        check("push_pop_one", o_tx_data, 8'h44);
        idle();
        step();
        i_tx_ready = 1'b0;
        rd_check("rsvd6", IO + 11'd6, 9'h000);
        rd_check("txdata_rd", IO + 11'd2, 9'h000);
        idle();

        // Tick snapshot coherency
        for (int n = 0; n < 2000 && tick_m < 16'h00FF; n++) step();
        rd_check("tick_lo", IO + 11'd4, 9'h0FF);
        step();
        idle();
        step();
        rd_check("tick_hi", IO + 11'd5, 9'h000);
        idle();

        // Reset mid-drain; RAM write on the reset edge is suppressed
        for (int i = 0; i < 3; i++) begin
            drive_wr(IO + 11'd2, 9'(8'hA1 + i));
            step();
        end
        wr(IO, 9'h055);
        i_tx_ready = 1'b1;
        step();
        i_rst = 1'b1;
        drive_wr(11'h123, 9'h0AA);
        step();
        idle();
        check("midrst_valid", o_tx_valid, 1'b0);
        check("midrst_gpo", o_gpo, 8'h00);
        rd_check("midrst_tick", IO + 11'd4, 9'h000);
        idle();
        i_rst = 1'b0;
        rd_check("ram_kept", 11'h123, 9'h1A5);
        idle();
        i_tx_ready = 1'b0;
        wr(IO + 11'd2, 9'h077);
        check("post_rst_push", o_tx_data, 8'h77);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
